// File: rtl/expr_eval.sv
// Single-digit arithmetic expression evaluator on an ASCII character stream.
// Tracks the running value with '*' binding tighter than '+'/'-'; sticky error on malformed input.
module expr_eval #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [7:0]       in,
  output logic             valid,
  output logic             err,
  output logic [WIDTH-1:0] result
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NUM  = 2'd1,
    OP   = 2'd2,
    ERR  = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0] term;
  logic [WIDTH-1:0] term_nxt;
  logic             pend_mul;
  logic             pend_mul_nxt;
  logic             neg;
  logic             neg_nxt;
  logic             valid_nxt;
  logic             err_nxt;
  logic [WIDTH-1:0] result_nxt;

  logic             is_digit;
  logic             is_addop;
  logic             is_mulop;
  logic [WIDTH-1:0] digit;

  // ASCII '0'..'9' carry their value in the low nibble
  assign is_digit = (in >= 8'h30) && (in <= 8'h39);
  assign is_addop = (in == 8'h2B) || (in == 8'h2D);
  assign is_mulop = (in == 8'h2A);
  assign digit    = WIDTH'(in[3:0]);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) state <= IDLE;
    else     state <= state_nxt;
  end

  // Grammar check plus datapath update for the character on this edge
  always_comb begin
    state_nxt    = state;
    acc_nxt      = acc;
    term_nxt     = term;
    pend_mul_nxt = pend_mul;
    neg_nxt      = neg;
    valid_nxt    = 1'b0;
    err_nxt      = 1'b0;
    result_nxt   = '0;

    case (state)
      IDLE, OP: begin
        if (is_digit) begin
          state_nxt = NUM;
          if (pend_mul) term_nxt = term * digit;
          else          term_nxt = neg ? -digit : digit;
        end else begin
          state_nxt = ERR;
        end
      end
      NUM: begin
        if (is_addop) begin
          state_nxt    = OP;
          acc_nxt      = acc + term;
          pend_mul_nxt = 1'b0;
          neg_nxt      = (in == 8'h2D);
        end else if (is_mulop) begin
          state_nxt    = OP;
          pend_mul_nxt = 1'b1;
        end else begin
          state_nxt = ERR;
        end
      end
      default: state_nxt = ERR;
    endcase

    // Outputs are registered copies of what the next state decodes to
    valid_nxt = (state_nxt == NUM);
    err_nxt   = (state_nxt == ERR);
    if (valid_nxt) result_nxt = acc_nxt + term_nxt;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      acc      <= '0;
      term     <= '0;
      pend_mul <= 1'b0;
      neg      <= 1'b0;
      valid    <= 1'b0;
      err      <= 1'b0;
      result   <= '0;
    end else begin
      acc      <= acc_nxt;
      term     <= term_nxt;
      pend_mul <= pend_mul_nxt;
      neg      <= neg_nxt;
      valid    <= valid_nxt;
      err      <= err_nxt;
      result   <= result_nxt;
    end
  end

endmodule

// File: tb/tb_expr_eval.sv
// Scoreboard bench for expr_eval: a string-level reference evaluator predicts each edge's outputs,
// a monitor pops and compares after every rising edge.
module tb_expr_eval;

  localparam int unsigned WIDTH = 16;

  typedef struct packed {
    logic             valid;
    logic             err;
    logic [WIDTH-1:0] result;
  } exp_t;

  logic             clk;
  logic             clr;
  logic [7:0]       in;
  logic             valid;
  logic             err;
  logic [WIDTH-1:0] result;

  int   n_checks;
  int   n_fails;
  exp_t exp_q[$];
  logic [7:0] hist[$];

  expr_eval #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .clr    (clr),
    .in     (in),
    .valid  (valid),
    .err    (err),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Re-evaluates the whole consumed string from scratch: even slots digits, odd slots operators
  function automatic exp_t model();
    exp_t e;
    bit   bad;
    int   sum;
    int   prod;
    int   d;
    bad  = 1'b0;
    sum  = 0;
    prod = 0;
    for (int i = 0; i < hist.size(); i++) begin
      if (i % 2 == 0) begin
        if (!(hist[i] >= "0" && hist[i] <= "9")) bad = 1'b1;
      end else begin
        if (!(hist[i] == "+" || hist[i] == "-" || hist[i] == "*")) bad = 1'b1;
      end
    end
    if (!bad) begin
      for (int i = 0; i < hist.size(); i += 2) begin
        d = int'(hist[i]) - 48;
        if (i > 0 && hist[i-1] == "*") begin
          prod = prod * d;
        end else begin
          if (i > 0) sum = sum + prod;
          prod = (i > 0 && hist[i-1] == "-") ? -d : d;
        end
      end
    end
    e.err    = bad;
    e.valid  = !bad && (hist.size() % 2 == 1);
    e.result = e.valid ? WIDTH'(sum + prod) : '0;
    return e;
  endfunction

  // Called at a falling edge; presents one character for the next rising edge
  task automatic send(input logic [7:0] c);
    in = c;
    hist.push_back(c);
    exp_q.push_back(model());
    @(negedge clk);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  // Asynchronous clear between edges, held across one edge whose character must be dropped
  task automatic pulse_clr();
    clr = 1'b1;
    #1;
    check("clr_async_valid", int'(valid), 0);
    check("clr_async_err", int'(err), 0);
    check("clr_async_result", int'(result), 0);
    @(posedge clk);
    #1;
    check("clr_edge_valid", int'(valid), 0);
    check("clr_edge_result", int'(result), 0);
    @(negedge clk);
    clr = 1'b0;
    hist.delete();
  endtask

  // Checks directly against hand-derived values from the test plan
  task automatic expect_now(input string name, input int v, input int e, input int r);
    check({name, "_valid"}, int'(valid), v);
    check({name, "_err"}, int'(err), e);
    check({name, "_result"}, int'(result), r);
  endtask

  function automatic logic [7:0] rand_char(input bit want_digit);
    logic [7:0] c;
    int k;
    if ($urandom_range(0, 24) == 0) begin
      c = 8'($urandom_range(0, 255));
    end else if (want_digit) begin
      c = 8'(48 + $urandom_range(0, 9));
    end else begin
      k = $urandom_range(0, 2);
      c = (k == 0) ? 8'h2B : (k == 1) ? 8'h2D : 8'h2A;
    end
    return c;
  endfunction

  // Monitor: every rising edge yields one response
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("sb_valid", int'(valid), int'(e.valid));
        check("sb_err", int'(err), int'(e.err));
        check("sb_result", int'(result), int'(e.result));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int len;
    n_checks = 0;
    n_fails  = 0;
    clr = 1'b1;
    in  = "0";
    @(negedge clk);
    @(negedge clk);
    expect_now("reset", 0, 0, 0);
    clr = 1'b0;

    send_str("1+2*3");
    expect_now("plan_1p2x3", 1, 0, 7);
    pulse_clr();

    send_str("9-2*3*4");
    expect_now("plan_neg15", 1, 0, 16'hFFF1);
    pulse_clr();

    send_str("12+3");
    expect_now("plan_double_digit", 0, 1, 0);
    pulse_clr();

    send("+");
    expect_now("plan_lead_op", 0, 1, 0);
    pulse_clr();

    send_str("3*a");
    expect_now("plan_illegal_in_op", 0, 1, 0);
    pulse_clr();
    send("5");
    expect_now("plan_after_clr", 1, 0, 5);
    pulse_clr();

    send_str("9*9*9*9*9*9");
    expect_now("plan_wrap", 1, 0, 16'h1BF1);
    pulse_clr();

    send_str("4*");
    pulse_clr();
    send_str("0-7");
    expect_now("plan_clr_mid", 1, 0, 16'hFFF9);

    // Random expressions, mostly well-formed, occasionally with a stray byte
    for (int n = 0; n < 60; n++) begin
      pulse_clr();
      len = $urandom_range(1, 25);
      for (int i = 0; i < len; i++) send(rand_char(i % 2 == 0));
    end

    @(negedge clk);
    check("sb_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
